alu_seq_param: RTL and testbench
================================

// Module: alu_seq_param
// PURPOSE
//  Parametrised, clocked successor to the combinational 8-bit ALU. It adds valid/ready
//  handshakes on input and output, an 8-entry opcode set, and an iterative shift-add
//  multiplier for MUL and SQR. Sits between a command source (sequencer/FSM) and a result
//  consumer. Results and flags are registered and held until the consumer accepts them.
// PARAMETERS
//  DATA_WIDTH  8           operand width
//  N           DATA_WIDTH  internal alias; result width is 2*N
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      command valid
//  in_ready   out  1      block can accept a command (high only in IDLE)
//  A          in   N      operand A (unsigned)
//  B          in   N      operand B (unsigned)
//  Cin        in   1      carry-in for ADD
//  Bin        in   1      borrow-in for SUB
//  op         in   3      000 ADD, 001 SUB, 010 CMP, 011 SQR, 100 MUL, 101 AND, 110 OR, 111 XOR
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  Y          out  2N     result
//  Cout       out  1      ADD carry-out; 0 for every other op
//  Bout       out  1      SUB borrow-out; 0 for every other op
//  gr/le/eq   out  1 each unsigned compare of captured A,B: A>B / A<B / A==B (valid for all ops)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, in_ready=1, out_valid=0, Y=0, all flags 0, counter 0.
//  - FSM states: IDLE, MUL, DONE. Accept = in_valid && in_ready on a rising edge.
//  - Inputs A/B/Cin/Bin/op are captured at accept; later changes have no effect.
//  - IDLE --accept, op in {ADD,SUB,CMP,AND,OR,XOR}--> DONE; result registered on that edge.
//  - IDLE --accept, op in {MUL,SQR}--> MUL; multiplicand=A, multiplier=B (MUL) or A (SQR),
//    acc=0, cnt=0.
//  - MUL: one multiplier bit per clock, LSB first. Add multiplicand<<cnt into acc when
//    the bit is 1. After N iterations (cnt==N-1) go to DONE with Y=acc.
//  - Latency from accept edge to out_valid high: 1 clock (simple ops), N+1 clocks (MUL/SQR).
//  - DONE: out_valid=1. Y and all flags stay stable while out_ready=0.
//    out_valid && out_ready on an edge -> IDLE, out_valid=0. Y and flags keep their last value.
//  - in_ready = (state==IDLE). No overlap of commands: a new command is ignored outside IDLE.
//    Peak throughput is 1 simple op per 2 clocks.
//  - Width rules:
//    ADD: {Cout,sum} = A+B+Cin; Y = {N'b0, sum}.
//    SUB: diff = (A-B-Bin) mod 2^N; Y = {N'b0, diff}; Bout = (A < B+Bin), evaluated in N+1 bits.
//    CMP: Y = {(2N-3)'b0, gr, le, eq}.
//    AND/OR/XOR: Y = {N'b0, A op B}.
//    MUL/SQR: full 2N-bit unsigned product; no truncation or overflow.
//  - Exactly one of gr/le/eq is 1 whenever out_valid=1.
//  - Reset during MUL or DONE: the result is discarded. After rst deasserts, in_ready=1 and the
//    next command behaves as if from cold reset.
//  - in_valid asserted during rst is ignored. No command is accepted on the edge where rst falls
//    unless in_valid is still high on a subsequent edge.
// TESTING (N=8)
//  1. ADD A=200,B=100,Cin=1 -> 1 clk later out_valid=1, Y=0x002D, Cout=1, gr=1.
//  2. SUB A=5,B=10,Bin=0 -> Y=0x00FB, Bout=1, le=1, Cout=0; SUB A=10,B=9,Bin=1 -> Y=0, Bout=0.
//  3. MUL A=0xFF,B=0xFF -> out_valid exactly 9 clks after accept, Y=0xFE01.
//     SQR A=0x10,B=x -> Y=0x0100. MUL A=0,B=0xAB -> Y=0.
//  4. Backpressure: CMP A=B=0x7F with out_ready=0 for 5 clks -> Y=0x0001, eq=1, stable,
//     in_ready=0. A second in_valid during the stall is not accepted. Raising out_ready
//     returns to IDLE.
//  5. Reset mid-MUL (3rd iteration) -> out_valid=0, Y=0, in_ready=1 immediately.
//     A following MUL 12*13 -> Y=0x009C.
//  6. Back-to-back with out_ready=1: XOR 0xF0^0x3C then OR 0x0F|0x30
//     -> 0x00CC, then 0x003F, one result every 2 clks, Cout=Bout=0.

Source files
------------

// File: rtl/alu_seq_param.sv
// Clocked ALU with valid/ready handshakes on both sides and an iterative shift-add
// multiplier for MUL/SQR. Results and flags are registered and held until accepted.
module alu_seq_param #(
   parameter int DATA_WIDTH = 8,
   parameter int N          = DATA_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   input  logic           Cin,
   input  logic           Bin,
   input  logic [2:0]     op,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] Y,
   output logic           Cout,
   output logic           Bout,
   output logic           gr,
   output logic           le,
   output logic           eq,
   output logic [1:0]     dbg_state_o
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_CMP = 3'b010;
   localparam logic [2:0] OP_SQR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Handshake: a transfer happens on a rising edge where valid && ready are both high.
   // in_ready is high only in IDLE; out_valid is high only in DONE, where Y/flags are held.
   state_t           state_q, state_d;
   logic [2*N-1:0]   mcand_q, mcand_d;
   logic [N-1:0]     mplier_q, mplier_d;
   logic [2*N-1:0]   acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2*N-1:0]   y_q, y_d;
   logic             cout_q, cout_d;
   logic             bout_q, bout_d;
   logic             gr_q, gr_d;
   logic             le_q, le_d;
   logic             eq_q, eq_d;

   logic [N:0]       add_w;
   logic [N:0]       sub_rhs_w;
   logic [N-1:0]     diff_w;
   logic             bout_w;
   logic             gr_w, le_w, eq_w;
   logic [2*N-1:0]   acc_sum_w;

   assign add_w     = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};
   assign sub_rhs_w = {1'b0, B} + {{N{1'b0}}, Bin};
   assign diff_w    = A - B - {{(N-1){1'b0}}, Bin};
   assign bout_w    = ({1'b0, A} < sub_rhs_w);
   assign gr_w      = (A > B);
   assign le_w      = (A < B);
   assign eq_w      = (A == B);
   // mcand_q is shifted left once per iteration, so it always equals multiplicand<<cnt.
   assign acc_sum_w = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      y_d      = y_q;
      cout_d   = cout_q;
      bout_d   = bout_q;
      gr_d     = gr_q;
      le_d     = le_q;
      eq_d     = eq_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               gr_d    = gr_w;
               le_d    = le_w;
               eq_d    = eq_w;
               cout_d  = 1'b0;
               bout_d  = 1'b0;
               state_d = S_DONE;
               case (op)
                  OP_ADD: begin
                     y_d    = {{N{1'b0}}, add_w[N-1:0]};
                     cout_d = add_w[N];
                  end
                  OP_SUB: begin
                     y_d    = {{N{1'b0}}, diff_w};
                     bout_d = bout_w;
                  end
                  OP_CMP: y_d = {{(2*N-3){1'b0}}, gr_w, le_w, eq_w};
                  OP_AND: y_d = {{N{1'b0}}, A & B};
                  OP_OR:  y_d = {{N{1'b0}}, A | B};
                  OP_XOR: y_d = {{N{1'b0}}, A ^ B};
                  default: begin
                     mcand_d  = {{N{1'b0}}, A};
                     mplier_d = (op == OP_SQR) ? A : B;
                     acc_d    = '0;
                     cnt_d    = '0;
                     state_d  = S_MUL;
                  end
               endcase
            end
         end
         S_MUL: begin
            acc_d    = acc_sum_w;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(N-1)) begin
               y_d     = acc_sum_w;
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         y_q      <= '0;
         cout_q   <= 1'b0;
         bout_q   <= 1'b0;
         gr_q     <= 1'b0;
         le_q     <= 1'b0;
         eq_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         y_q      <= y_d;
         cout_q   <= cout_d;
         bout_q   <= bout_d;
         gr_q     <= gr_d;
         le_q     <= le_d;
         eq_q     <= eq_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign Y           = y_q;
   assign Cout        = cout_q;
   assign Bout        = bout_q;
   assign gr          = gr_q;
   assign le          = le_q;
   assign eq          = eq_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed self-checking bench for alu_seq_param (N=8): one task per scenario.
module tb_alu_seq_param;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_CMP = 3'b010;
   localparam logic [2:0] OP_SQR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  A, B;
   logic        Cin, Bin;
   logic [2:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] Y;
   logic        Cout, Bout, gr, le, eq;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_seq_param #(.DATA_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Cin(Cin), .Bin(Bin), .op(op),
      .out_valid(out_valid), .out_ready(out_ready), .Y(Y),
      .Cout(Cout), .Bout(Bout), .gr(gr), .le(le), .eq(eq),
      .dbg_state_o(dbg_state)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present one command at a negedge, return #1 after its accept edge with in_valid low.
   // Operands are scrambled afterwards so late changes would be visible.
   task automatic do_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic bi);
      @(negedge clk);
      op = o; A = a; B = b; Cin = ci; Bin = bi; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A = ~a; B = ~b; Cin = ~ci; Bin = ~bi;
   endtask

   // Counts edges from the accept edge (inclusive) until out_valid is seen.
   task automatic wait_result(output int cycles);
      cycles = 1;
      while (!out_valid && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      op = OP_ADD; A = 8'd1; B = 8'd2; Cin = 1'b0; Bin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_hs: in_ready/out_valid=%b expected 10", {in_ready, out_valid});
      end
      n_checks++;
      if ({Y, Cout, Bout, gr, le, eq} !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_data: Y=%h flags=%b expected 0", Y, {Cout, Bout, gr, le, eq});
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_release: in_ready/out_valid=%b expected 10", {in_ready, out_valid});
      end
   endtask

   task automatic test_add;
      do_cmd(OP_ADD, 8'd200, 8'd100, 1'b1, 1'b0);
      n_checks++;
      if ({out_valid, in_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL add_latency: out_valid/in_ready=%b expected 10", {out_valid, in_ready});
      end
      n_checks++;
      if ({Y, Cout, Bout, gr, le, eq} !== {16'h002D, 5'b10100}) begin
         n_fail++;
         $display("FAIL add_result: Y=%h flags=%b expected 002d 10100", Y, {Cout, Bout, gr, le, eq});
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, in_ready, Y} !== {2'b01, 16'h002D}) begin
         n_fail++;
         $display("FAIL add_release: ov/ir=%b Y=%h expected 01 002d", {out_valid, in_ready}, Y);
      end
   endtask

   task automatic test_sub;
      do_cmd(OP_SUB, 8'd5, 8'd10, 1'b0, 1'b0);
      n_checks++;
      if ({out_valid, Y, Cout, Bout, gr, le, eq} !== {1'b1, 16'h00FB, 5'b01010}) begin
         n_fail++;
         $display("FAIL sub_borrow: ov=%b Y=%h flags=%b expected 1 00fb 01010",
                  out_valid, Y, {Cout, Bout, gr, le, eq});
      end
      @(posedge clk);
      do_cmd(OP_SUB, 8'd10, 8'd9, 1'b0, 1'b1);
      n_checks++;
      if ({out_valid, Y, Cout, Bout, gr, le, eq} !== {1'b1, 16'h0000, 5'b00100}) begin
         n_fail++;
         $display("FAIL sub_zero: ov=%b Y=%h flags=%b expected 1 0000 00100",
                  out_valid, Y, {Cout, Bout, gr, le, eq});
      end
      @(posedge clk);
   endtask

   task automatic test_mul;
      int cyc;
      do_cmd(OP_MUL, 8'hFF, 8'hFF, 1'b1, 1'b1);
      wait_result(cyc);
      n_checks++;
      if (cyc !== 9) begin
         n_fail++;
         $display("FAIL mul_latency: %0d clocks expected 9", cyc);
      end
      n_checks++;
      if ({out_valid, Y, Cout, Bout, gr, le, eq} !== {1'b1, 16'hFE01, 5'b00001}) begin
         n_fail++;
         $display("FAIL mul_ff: ov=%b Y=%h flags=%b expected 1 fe01 00001",
                  out_valid, Y, {Cout, Bout, gr, le, eq});
      end
      @(posedge clk);
      do_cmd(OP_SQR, 8'h10, 8'h55, 1'b0, 1'b0);
      wait_result(cyc);
      n_checks++;
      if ({cyc == 9, out_valid, Y, gr, le, eq} !== {2'b11, 16'h0100, 3'b010}) begin
         n_fail++;
         $display("FAIL sqr_10: cyc=%0d ov=%b Y=%h cmp=%b expected 9 1 0100 010",
                  cyc, out_valid, Y, {gr, le, eq});
      end
      @(posedge clk);
      do_cmd(OP_MUL, 8'h00, 8'hAB, 1'b0, 1'b0);
      wait_result(cyc);
      n_checks++;
      if ({out_valid, Y, Cout, Bout, gr, le, eq} !== {1'b1, 16'h0000, 5'b00010}) begin
         n_fail++;
         $display("FAIL mul_zero: ov=%b Y=%h flags=%b expected 1 0000 00010",
                  out_valid, Y, {Cout, Bout, gr, le, eq});
      end
      @(posedge clk);
   endtask

   task automatic test_backpressure;
      @(negedge clk);
      out_ready = 1'b0;
      do_cmd(OP_CMP, 8'h7F, 8'h7F, 1'b0, 1'b0);
      @(negedge clk);
      op = OP_ADD; A = 8'h01; B = 8'h01; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if ({out_valid, in_ready, Y, gr, le, eq} !== {2'b10, 16'h0001, 3'b001}) begin
            n_fail++;
            $display("FAIL stall_%0d: ov/ir=%b Y=%h cmp=%b expected 10 0001 001",
                     i, {out_valid, in_ready}, Y, {gr, le, eq});
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, in_ready, Y} !== {2'b01, 16'h0001}) begin
         n_fail++;
         $display("FAIL stall_release: ov/ir=%b Y=%h expected 01 0001", {out_valid, in_ready}, Y);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, Y} !== {1'b0, 16'h0001}) begin
         n_fail++;
         $display("FAIL stall_ignored: ov=%b Y=%h expected 0 0001", out_valid, Y);
      end
   endtask

   task automatic test_reset_mid_mul;
      int cyc;
      do_cmd(OP_MUL, 8'h77, 8'h55, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({in_ready, out_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL mul_busy: in_ready/out_valid=%b expected 00", {in_ready, out_valid});
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({in_ready, out_valid, Y, Cout, Bout, gr, le, eq} !== {2'b10, 21'd0}) begin
         n_fail++;
         $display("FAIL mid_reset: ir/ov=%b Y=%h flags=%b expected 10 0000 00000",
                  {in_ready, out_valid}, Y, {Cout, Bout, gr, le, eq});
      end
      @(negedge clk);
      rst = 1'b0;
      do_cmd(OP_MUL, 8'd12, 8'd13, 1'b0, 1'b0);
      wait_result(cyc);
      n_checks++;
      if ({cyc == 9, out_valid, Y, Cout, Bout, gr, le, eq} !== {2'b11, 16'h009C, 5'b00010}) begin
         n_fail++;
         $display("FAIL mul_after_reset: cyc=%0d ov=%b Y=%h flags=%b expected 9 1 009c 00010",
                  cyc, out_valid, Y, {Cout, Bout, gr, le, eq});
      end
      @(posedge clk);
   endtask

   task automatic test_logic_cmp;
      do_cmd(OP_AND, 8'hC3, 8'h5A, 1'b1, 1'b1);
      n_checks++;
      if ({out_valid, Y, Cout, Bout, gr, le, eq} !== {1'b1, 16'h0042, 5'b00100}) begin
         n_fail++;
         $display("FAIL and: ov=%b Y=%h flags=%b expected 1 0042 00100",
                  out_valid, Y, {Cout, Bout, gr, le, eq});
      end
      @(posedge clk);
      do_cmd(OP_CMP, 8'h80, 8'h01, 1'b0, 1'b0);
      n_checks++;
      if ({out_valid, Y} !== {1'b1, 16'h0004}) begin
         n_fail++;
         $display("FAIL cmp_gr: ov=%b Y=%h expected 1 0004", out_valid, Y);
      end
      @(posedge clk);
      do_cmd(OP_CMP, 8'h01, 8'h80, 1'b0, 1'b0);
      n_checks++;
      if ({out_valid, Y} !== {1'b1, 16'h0002}) begin
         n_fail++;
         $display("FAIL cmp_le: ov=%b Y=%h expected 1 0002", out_valid, Y);
      end
      @(posedge clk);
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      out_ready = 1'b1;
      op = OP_XOR; A = 8'hF0; B = 8'h3C; Cin = 1'b1; Bin = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, Y, Cout, Bout, gr, le, eq} !== {1'b1, 16'h00CC, 5'b00100}) begin
         n_fail++;
         $display("FAIL b2b_xor: ov=%b Y=%h flags=%b expected 1 00cc 00100",
                  out_valid, Y, {Cout, Bout, gr, le, eq});
      end
      op = OP_OR; A = 8'h0F; B = 8'h30;
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL b2b_gap: ov/ir=%b expected 01", {out_valid, in_ready});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, Y, Cout, Bout, gr, le, eq} !== {1'b1, 16'h003F, 5'b00010}) begin
         n_fail++;
         $display("FAIL b2b_or: ov=%b Y=%h flags=%b expected 1 003f 00010",
                  out_valid, Y, {Cout, Bout, gr, le, eq});
      end
      @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_backpressure();
      test_reset_mid_mul();
      test_logic_cmp();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
